// File: rtl/linear_layer_srl_fifo_hs.sv
// Shift-register FIFO with full/empty handshake, element count and almost-full flag.
// Optional registered output stage: define LINEAR_LAYER_FIFO_OUTREG_EN.
module linear_layer_srl_fifo_hs #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned AFULL_LEVEL = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    output logic                  if_almost_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic [ADDR_WIDTH+1:0] if_num_data_valid
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam int unsigned NV_W  = ADDR_WIDTH + 2;

    logic [DATA_WIDTH-1:0] srl [DEPTH];
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_nxt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic                  srl_empty_n;
    logic                  push;
    logic                  srl_pop;
    logic [DATA_WIDTH-1:0] head;

    assign push = if_write & if_write_ce & if_full_n;
    assign head = srl[addr];

    // Storage has no reset so it maps onto SRL primitives.
    always_ff @(posedge clk) begin
        if (push) begin
            srl[0] <= if_din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                srl[i] <= srl[i-1];
            end
        end
    end

    // Next count: push&pop leaves count and address unchanged while data shifts under the head.
    always_comb begin
        cnt_nxt = cnt;
        if (push && !srl_pop) begin
            cnt_nxt = cnt + CNT_W'(1);
        end else if (!push && srl_pop) begin
            cnt_nxt = cnt - CNT_W'(1);
        end
        addr_nxt = (cnt_nxt == '0) ? '0 : ADDR_WIDTH'(cnt_nxt - CNT_W'(1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt              <= '0;
            addr             <= '0;
            srl_empty_n      <= 1'b0;
            if_full_n        <= 1'b1;
            if_almost_full_n <= 1'b1;
        end else begin
            cnt              <= cnt_nxt;
            addr             <= addr_nxt;
            srl_empty_n      <= (cnt_nxt != '0);
            if_full_n        <= (cnt_nxt != CNT_W'(DEPTH));
            if_almost_full_n <= (cnt_nxt < CNT_W'(AFULL_LEVEL));
        end
    end

`ifdef LINEAR_LAYER_FIFO_OUTREG_EN
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  pop;
    logic                  refill;

    assign pop     = if_read & if_read_ce & out_valid;
    // Output register takes the SRL head whenever it is empty or being drained this cycle.
    assign refill  = !out_valid || pop;
    assign srl_pop = refill & srl_empty_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
        end else if (refill) begin
            out_valid <= srl_empty_n;
        end
    end

    always_ff @(posedge clk) begin
        if (srl_pop) begin
            out_data <= head;
        end
    end

    assign if_dout           = out_data;
    assign if_empty_n        = out_valid;
    assign if_num_data_valid = NV_W'(cnt) + NV_W'(out_valid);
`else
    assign srl_pop           = if_read & if_read_ce & srl_empty_n;
    assign if_dout           = head;
    assign if_empty_n        = srl_empty_n;
    assign if_num_data_valid = NV_W'(cnt);
`endif

endmodule

// File: tb/tb_linear_layer_srl_fifo_hs.sv
// Directed and randomised checks of linear_layer_srl_fifo_hs (default build, DEPTH=16, AFULL=14).
module tb_linear_layer_srl_fifo_hs;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_write_ce, if_write, if_read_ce, if_read;
    logic [31:0] if_din;
    logic        if_full_n, if_almost_full_n, if_empty_n;
    logic [31:0] if_dout;
    logic [5:0]  if_num_data_valid;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] model_q[$];

    linear_layer_srl_fifo_hs #(
        .DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(4), .AFULL_LEVEL(14)
    ) dut (
        .clk(clk), .reset(reset),
        .if_write_ce(if_write_ce), .if_write(if_write), .if_din(if_din),
        .if_full_n(if_full_n), .if_almost_full_n(if_almost_full_n),
        .if_read_ce(if_read_ce), .if_read(if_read), .if_dout(if_dout),
        .if_empty_n(if_empty_n), .if_num_data_valid(if_num_data_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_write = 1'b0; if_read = 1'b0; if_write_ce = 1'b1; if_read_ce = 1'b1;
    endtask

    task automatic push_one(input logic [31:0] d);
        if_write = 1'b1; if_din = d;
        step();
        if_write = 1'b0;
    endtask

    task automatic pop_one();
        if_read = 1'b1;
        step();
        if_read = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_empty_n"}, 64'(if_empty_n), 64'd0);
        check({tag, "_full_n"}, 64'(if_full_n), 64'd1);
        check({tag, "_afull_n"}, 64'(if_almost_full_n), 64'd1);
        check({tag, "_count"}, 64'(if_num_data_valid), 64'd0);
    endtask

    initial begin
        reset = 1'b1; if_din = '0;
        idle();
        repeat (3) step();
        check_idle("rst");
        reset = 1'b0;
        step();

        // 1: single write visible next cycle
        push_one(32'h11);
        check("t1_empty_n", 64'(if_empty_n), 64'd1);
        check("t1_dout", 64'(if_dout), 64'h11);
        check("t1_count", 64'(if_num_data_valid), 64'd1);
        pop_one();
        check_idle("t1_drain");

        // 2: fill to full, flags at 14 and 16, overflow write ignored
        for (int i = 0; i < 16; i++) begin
            push_one(32'(i));
            check("t2_afull_n", 64'(if_almost_full_n), 64'((i + 1) < 14));
            check("t2_full_n", 64'(if_full_n), 64'((i + 1) != 16));
        end
        push_one(32'hFF);
        check("t2_overflow_count", 64'(if_num_data_valid), 64'd16);
        check("t2_overflow_head", 64'(if_dout), 64'd0);

        // 4: read without clock-enable is no pop; write while full keeps count
        if_read = 1'b1; if_read_ce = 1'b0; if_write = 1'b1; if_din = 32'hEE;
        step();
        idle();
        check("t4_count", 64'(if_num_data_valid), 64'd16);
        check("t4_head", 64'(if_dout), 64'd0);
        check("t4_full_n", 64'(if_full_n), 64'd0);

        for (int i = 0; i < 16; i++) begin
            check("t2_read_order", 64'(if_dout), 64'(i));
            pop_one();
        end
        check_idle("t2_drain");

        // 3: steady count 5 with simultaneous push and pop
        for (int i = 0; i < 5; i++) push_one(32'h50 + 32'(i));
        for (int i = 0; i < 10; i++) begin
            check("t3_head", 64'(if_dout), (i < 5) ? 64'(32'h50 + 32'(i)) : 64'hA5);
            if_write = 1'b1; if_din = 32'hA5; if_read = 1'b1;
            step();
            idle();
            check("t3_count", 64'(if_num_data_valid), 64'd5);
        end
        for (int i = 0; i < 5; i++) begin
            check("t3_tail", 64'(if_dout), 64'hA5);
            pop_one();
        end
        check_idle("t3_drain");

        // 5: asynchronous reset mid-burst
        for (int i = 0; i < 9; i++) push_one(32'h90 + 32'(i));
        check("t5_count_pre", 64'(if_num_data_valid), 64'd9);
        if_write = 1'b1; if_din = 32'hAB;
        #2 reset = 1'b1;
        #1;
        check_idle("t5_async");
        idle();
        step();
        #2 reset = 1'b0;
        step();
        check_idle("t5_after");
        push_one(32'h77);
        check("t5_dout", 64'(if_dout), 64'h77);
        check("t5_count", 64'(if_num_data_valid), 64'd1);
        pop_one();
        check_idle("t5_drain");

        // 6: random traffic against a queue model
        model_q.delete();
        for (int c = 0; c < 3000; c++) begin
            logic do_push, do_pop;
            if_write    = 1'($urandom_range(0, 1));
            if_write_ce = ($urandom_range(0, 7) != 0);
            if_read     = 1'($urandom_range(0, 1));
            if_read_ce  = ($urandom_range(0, 7) != 0);
            if_din      = $urandom;
            do_push = if_write && if_write_ce && (model_q.size() < 16);
            do_pop  = if_read && if_read_ce && (model_q.size() > 0);
            if (model_q.size() > 0) check("t6_head", 64'(if_dout), 64'(model_q[0]));
            step();
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(if_din);
            check("t6_count", 64'(if_num_data_valid), 64'(model_q.size()));
            if (if_empty_n !== (model_q.size() != 0) || if_full_n !== (model_q.size() != 16)
                || if_almost_full_n !== (model_q.size() < 14))
                check("t6_flags", {61'd0, if_empty_n, if_full_n, if_almost_full_n},
                      {61'd0, model_q.size() != 0, model_q.size() != 16, model_q.size() < 14});
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
